serial_adder: RTL and testbench
===============================

# serial_adder

Multi-cycle, parametrised bit-serial adder/subtractor built from a chain of STEP full-adder cells and a registered carry. It processes WIDTH-bit operands LSB-first, STEP bits per clock, trading latency for area. It sits behind a valid/ready request port and in front of a valid/ready result port, so it drops into any datapath that tolerates multi-cycle arithmetic.

## Interface
- WIDTH, 16, operand/result width in bits; ≥ 2.
- STEP, 1, bits processed per cycle; 1 ≤ STEP ≤ WIDTH, WIDTH % STEP == 0.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- a  in  WIDTH  operand A; sampled only at acceptance.
- b  in  WIDTH  operand B; sampled only at acceptance.
- c_in  in  1  carry-in (add) or borrow-in (sub); sampled at acceptance.
- sub  in  1  0 = add, 1 = subtract; sampled at acceptance.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- c_out  out  1  raw carry out of MSB.
- ovf  out  1  signed overflow (present only with SERIAL_ADDER_OVF_EN).

## Operation
- N = WIDTH/STEP cycles per operation.
- States: IDLE, RUN, HOLD.
  - IDLE: in_ready=1. When in_valid=1, request accepted:
    - latch a, and b XOR {WIDTH{sub}};
    - carry register ← c_in XOR sub;
    - clear step counter;
    - → RUN.
  - RUN: each cycle, the low STEP bits of the operand registers pass through STEP rippled full-adder cells seeded by the carry register.
    - Result bits shift into the result register from the MSB side; operands shift right by STEP; carry register ← carry out of the cell chain; counter increments.
    - On the N-th RUN cycle: → HOLD.
  - HOLD: res_valid=1. When res_ready=1, → IDLE.
- Arithmetic:
  - add: {c_out,sum} = a + b + c_in.
  - sub: {c_out,sum} = a + ~b + ~c_in = a − b − c_in mod 2^WIDTH. c_out=1 means no borrow; c_out=0 means borrow.
- ovf: carry into MSB cell XOR carry out of MSB cell, i.e. two's-complement overflow of the add/sub as computed.
- in_valid while not in IDLE is ignored. No request queueing.
- sum, c_out, ovf are defined only while res_valid=1. While res_valid=1 they are held stable until the handshake completes.

## Timing
- Reset: any clock edge with rst_n=0 aborts any operation and forces state IDLE. Register values after reset: res_valid=0, sum=0, c_out=0, ovf=0, carry=0, counter=0. in_ready=1 from the first cycle after reset.
- Request accepted at edge T (in_valid & in_ready). RUN occupies edges T+1..T+N; res_valid rises after edge T+N.
- Result handshake at edge H (res_valid & res_ready). in_ready=1 in the cycle after H.
- Minimum period: N+2 cycles per operation. There is no accept in the same cycle as a result handshake.
- res_ready=1 while not in HOLD has no effect.
- Reset mid-RUN or mid-HOLD: the operation is discarded and no res_valid pulse is produced.
- The combinational path is STEP full-adder cells deep. STEP=WIDTH gives a single-cycle ripple adder with latency 1.

## Configuration
- SERIAL_ADDER_OVF_EN:
  - Defined: ovf port present, plus one extra flop that captures MSB carry-in on the final RUN cycle. ovf resets to 0.
  - Undefined: ovf port and its logic absent. All other behaviour is identical.

## Test plan
- Reset, then idle: hold rst_n=0 for 2 cycles, then release. Required: res_valid=0, in_ready=1, sum=0x0000, c_out=0.
- Add, WIDTH=16, STEP=1: a=0x1234, b=0x4321, c_in=0, sub=0. Required: res_valid exactly 16 edges after acceptance; sum=0x5555, c_out=0, ovf=0.
- Carry ripple: a=0xFFFF, b=0x0001, c_in=1. Required: sum=0x0001, c_out=1, ovf=0.
- Subtract:
  - a=0x0005, b=0x0007, c_in=0, sub=1. Required: sum=0xFFFE, c_out=0.
  - a=0x8000, b=0x0001, sub=1. Required: sum=0x7FFF, c_out=1, ovf=1.
- Backpressure: hold res_ready=0 for 5 cycles in HOLD while driving in_valid=1 with new operands. Required: res_valid and sum held stable, in_ready=0, new request not accepted until the cycle after the handshake.
- Reset mid-RUN and STEP variant:
  - rst_n=0 at RUN cycle 8. Required: no res_valid, in_ready=1 next cycle.
  - Rerun the add test with STEP=4. Required: latency 4, same sum.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, STEP bits per clock, valid/ready on both sides
// Optional signed overflow output is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
   parameter int WIDTH = 16,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             c_out
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [STEP-1:0]       chunk;
   logic                  chain_cout;
   logic [WIDTH+STEP-1:0] res_wide;
   logic                  last_step;

`ifdef SERIAL_ADDER_OVF_EN
   logic msb_cin_q, msb_cin_d;
   logic msb_cin;
`endif

   // Ripple chain over the low STEP bits, seeded by the registered carry.
   always_comb begin : chain
      logic c;
      c     = carry_q;
      chunk = '0;
`ifdef SERIAL_ADDER_OVF_EN
      msb_cin = 1'b0;
`endif
      for (int i = 0; i < STEP; i++) begin
`ifdef SERIAL_ADDER_OVF_EN
         if (i == STEP - 1) msb_cin = c;
`endif
         chunk[i] = a_q[i] ^ b_q[i] ^ c;
         c        = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
      end
      chain_cout = c;
   end

   assign res_wide  = {chunk, res_q};
   assign last_step = (cnt_q == CW'(N - 1));

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      carry_d   = carry_q;
      cnt_d     = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
      msb_cin_d = msb_cin_q;
`endif
      in_ready  = (state_q == IDLE);
      res_valid = (state_q == HOLD);
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               carry_d = c_in ^ sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d   = res_wide[WIDTH+STEP-1:STEP];
            a_d     = a_q >> STEP;
            b_d     = b_q >> STEP;
            carry_d = chain_cout;
            cnt_d   = cnt_q + CW'(1);
            if (last_step) begin
               state_d = HOLD;
`ifdef SERIAL_ADDER_OVF_EN
               msb_cin_d = msb_cin;
`endif
            end
         end
         HOLD: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         msb_cin_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         res_q     <= res_d;
         carry_q   <= carry_d;
         cnt_q     <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
         msb_cin_q <= msb_cin_d;
`endif
      end
   end

   assign sum   = res_q;
   assign c_out = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
   // Carry into the MSB cell versus carry out of it; both are zero after reset.
   assign ovf   = msb_cin_q ^ carry_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - random + directed bench for serial_adder, STEP=1 and STEP=4 instances
// Checks ovf too when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, c_in, sub;
   logic [15:0] a, b;
   logic [1:0]  ir, rv, rr, co;
   logic [1:0][15:0] sm;
`ifdef SERIAL_ADDER_OVF_EN
   logic [1:0]  ov;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic rst_edge = 1'b0;
   bit started = 1'b0;

   bit [1:0]    pend = 2'b00;
   int          acc_edge [2];
   logic [17:0] expv [2];
   int          nst [2] = '{16, 4};

   serial_adder #(.WIDTH(16), .STEP(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .a(a), .b(b), .c_in(c_in), .sub(sub),
      .res_valid(rv[0]), .res_ready(rr[0]), .sum(sm[0]),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf(ov[0]),
`endif
      .c_out(co[0]));

   serial_adder #(.WIDTH(16), .STEP(4)) u_s4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .a(a), .b(b), .c_in(c_in), .sub(sub),
      .res_valid(rv[1]), .res_ready(rr[1]), .sum(sm[1]),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf(ov[1]),
`endif
      .c_out(co[1]));

   // Reference result as {ovf, c_out, sum}, from plain integer arithmetic.
   function automatic logic [17:0] model(input logic [15:0] a_i, input logic [15:0] b_i,
                                         input logic ci, input logic sb);
      logic [15:0] bb;
      logic        cc;
      logic [16:0] full;
      int          sv;
      logic        o;
      bb   = sb ? ~b_i : b_i;
      cc   = ci ^ sb;
      full = {1'b0, a_i} + {1'b0, bb} + {16'd0, cc};
      sv   = int'($signed(a_i)) + int'($signed(bb)) + int'(cc);
      o    = (sv > 32767) || (sv < -32768);
      return {o, full};
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t got %h want %h", name, k, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_edge <= !rst_n;
   end

   always @(negedge clk) begin
      if (rst_edge) started = 1'b1;
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            logic exp_rv;
            bit   was;
            if (rst_edge) begin
               pend[k] = 1'b0;
               chk("rst_sum", k, 32'(sm[k]), 32'd0);
               chk("rst_cout", k, 32'(co[k]), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
               chk("rst_ovf", k, 32'(ov[k]), 32'd0);
`endif
            end
            was    = pend[k];
            exp_rv = was && (cyc >= acc_edge[k] + nst[k]);
            chk("res_valid", k, 32'(rv[k]), 32'(exp_rv));
            chk("in_ready", k, 32'(ir[k]), 32'(!was));
            if (exp_rv) begin
               chk("sum", k, 32'(sm[k]), 32'(expv[k][15:0]));
               chk("c_out", k, 32'(co[k]), 32'(expv[k][16]));
`ifdef SERIAL_ADDER_OVF_EN
               chk("ovf", k, 32'(ov[k]), 32'(expv[k][17]));
`endif
               if (rr[k]) pend[k] = 1'b0;
            end else if (!was && in_valid && rst_n) begin
               pend[k]     = 1'b1;
               acc_edge[k] = cyc + 1;
               expv[k]     = model(a, b, c_in, sub);
            end
         end
      end
   end

   task automatic wait_idle();
      int t;
      t = 0;
      while (ir != 2'b11 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) chk("idle_timeout", 0, 32'(ir), 32'h3);
   endtask

   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb);
      wait_idle();
      a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; rr = 2'b11;

      chk("pin_add",   0, 32'(model(16'h1234, 16'h4321, 1'b0, 1'b0)), 32'h05555);
      chk("pin_ripple",0, 32'(model(16'hFFFF, 16'h0001, 1'b1, 1'b0)), 32'h10001);
      chk("pin_sub",   0, 32'(model(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'h0FFFE);
      chk("pin_subovf",0, 32'(model(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'h37FFF);

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      send(16'h1234, 16'h4321, 1'b0, 1'b0);
      send(16'hFFFF, 16'h0001, 1'b1, 1'b0);
      send(16'h0005, 16'h0007, 1'b0, 1'b1);
      send(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_idle();

      // Backpressure: results held while new requests are offered.
      rr = 2'b00;
      send(16'h1111, 16'h2222, 1'b0, 1'b0);
      a = 16'hABCD; b = 16'h1357; in_valid = 1'b1;
      repeat (21) @(posedge clk);
      #1 rr = 2'b11;
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
      wait_idle();

      // Reset in the middle of RUN.
      send(16'h0F0F, 16'h7777, 1'b1, 1'b0);
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_idle();

      for (int i = 0; i < 1500; i++) begin
         logic [2:0] pick;
         @(posedge clk); #1;
         pick     = 3'($urandom_range(0, 4));
         in_valid = ($urandom_range(0, 3) != 0);
         a        = (pick == 0) ? 16'hFFFF : (pick == 1) ? 16'h8000 : (pick == 2) ? 16'h7FFF : 16'($urandom);
         b        = (pick == 3) ? 16'h0001 : 16'($urandom);
         c_in     = 1'($urandom);
         sub      = 1'($urandom);
         rr       = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         rst_n    = ($urandom_range(0, 299) != 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0; rr = 2'b11;
      repeat (40) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
